// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin 4:1 mux arbiter.
package rr_mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Debug view of the arbiter internals; hold_cnt is zero-extended to a fixed width.
  typedef struct packed {
    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [7:0]       hold_cnt;
  } dbg_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester/mux-side bundle of the round-robin mux arbiter.
interface rr_mux_arbiter_if;
  import rr_mux_arb_pkg::*;

  // req is a level: a source holds its bit high for as long as it wants the mux and
  // owns the datapath in every cycle its gnt bit is high; dropping req releases it.
  logic [NUM_REQ-1:0] req;
  logic               d0;
  logic               d1;
  logic               d2;
  logic               d3;
  logic [NUM_REQ-1:0] gnt;
  logic               s0;
  logic               s1;
  logic               y;
  logic               busy;

  modport master (output req, d0, d1, d2, d3, input gnt, s0, s1, y, busy);
  modport slave  (input req, d0, d1, d2, d3, output gnt, s0, s1, y, busy);

endinterface

// File: rtl/rr_mux_arbiter_pick4.sv
// Combinational round-robin pick: first eligible request after ptr, wrapping 3->0.
module rr_pick4
  import rr_mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] excl,
  output logic [SEL_W-1:0]   idx,
  output logic               valid
);

  logic [NUM_REQ-1:0] elig;
  logic [SEL_W-1:0]   cand;

  assign elig = req & ~excl;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (elig[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the 4:1 single-bit mux: grants, drives selects, registers y.
module rr_mux_arbiter
  import rr_mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  rr_mux_arbiter_if.slave   bus,
  output dbg_t              dbg
);

  // Unlimited hold still needs a one-bit counter; it then just saturates at 1.
  localparam int HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM =
    (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD);

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] gnt, gnt_nxt;
  logic [SEL_W-1:0]   sel, sel_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic               y;

  logic [NUM_REQ-1:0] dv;
  logic [SEL_W-1:0]   pick_ptr, pick_idx;
  logic [NUM_REQ-1:0] pick_excl;
  logic               pick_valid;
  logic               others;
  logic               forced;

  assign dv = {bus.d3, bus.d2, bus.d1, bus.d0};

  // Idle picks after the last-granted index; a handoff picks after the current owner.
  assign pick_ptr  = (state == ST_GRANT) ? sel : ptr;
  assign pick_excl = (state == ST_GRANT) ? onehot(sel) : '0;

  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .excl  (pick_excl),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign others = |(bus.req & ~onehot(sel));
  assign forced = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM) && others;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt = ST_GRANT;
          gnt_nxt   = onehot(pick_idx);
          sel_nxt   = pick_idx;
          hold_nxt  = HOLD_W'(1);
        end
      end
      ST_GRANT: begin
        if (bus.req[sel] && !forced) begin
          if (hold_cnt != HOLD_LIM) hold_nxt = hold_cnt + HOLD_W'(1);
        end else begin
          ptr_nxt = sel;
          if (pick_valid) begin
            gnt_nxt  = onehot(pick_idx);
            sel_nxt  = pick_idx;
            hold_nxt = HOLD_W'(1);
          end else begin
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
            sel_nxt   = '0;
            hold_nxt  = '0;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      sel      <= '0;
      ptr      <= SEL_W'(NUM_REQ - 1);
      hold_cnt <= '0;
      y        <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      y        <= (|gnt) ? dv[sel] : 1'b0;
    end
  end

  assign bus.gnt  = gnt;
  assign bus.s0   = sel[1];
  assign bus.s1   = sel[0];
  assign bus.y    = y;
  assign bus.busy = (state == ST_GRANT);

  assign dbg.state    = state;
  assign dbg.ptr      = ptr;
  assign dbg.hold_cnt = 8'(hold_cnt);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus random traffic against a queue-fed reference model.
module tb_rr_mux_arbiter;
  import rr_mux_arb_pkg::*;

  localparam int MAXH = 2;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic rst;
  dbg_t dbg;

  rr_mux_arbiter_if bus ();

  rr_mux_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .dbg (dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  // Reference model: owner index (-1 = idle), hold count, last-granted pointer, y.
  int m_cur  = -1;
  int m_hold = 0;
  int m_ptr  = 3;
  int m_y    = 0;

  function automatic int first_after(int start, logic [3:0] r, int skip);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (start + k) % 4;
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic [3:0] g;
    logic [1:0] s;
    g = (m_cur < 0) ? 4'b0000 : 4'(1 << m_cur);
    s = (m_cur < 0) ? 2'd0 : 2'(m_cur);
    return {g, s[1], s[0], m_y[0], (m_cur >= 0)};
  endfunction

  task automatic model_edge();
    logic [3:0] r;
    logic [3:0] d;
    int new_y;
    int p;
    r = bus.req;
    d = {bus.d3, bus.d2, bus.d1, bus.d0};
    if (rst) begin
      m_cur = -1; m_hold = 0; m_ptr = 3; m_y = 0;
    end else begin
      new_y = (m_cur >= 0) ? int'(d[m_cur]) : 0;
      if (m_cur < 0) begin
        p = first_after(m_ptr, r, -1);
        if (p >= 0) begin m_cur = p; m_hold = 1; end
      end else if (r[m_cur] && !(m_hold == MAXH && (r & ~4'(1 << m_cur)) != 0)) begin
        if (m_hold < MAXH) m_hold++;
      end else begin
        m_ptr = m_cur;
        p = first_after(m_cur, r, m_cur);
        if (p >= 0) begin m_cur = p; m_hold = 1; end
        else begin m_cur = -1; m_hold = 0; end
      end
      m_y = new_y;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_vec());
    #1;
  endtask

  function automatic logic [W-1:0] obs_vec();
    return {bus.gnt, bus.s0, bus.s1, bus.y, bus.busy};
  endfunction

  task automatic test_reset();
    logic [W-1:0] e;
    rst = 1'b1; bus.req = 4'b1111;
    bus.d0 = 1'b1; bus.d1 = 1'b1; bus.d2 = 1'b1; bus.d3 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== 8'b0000_0000 || obs_vec() !== e) begin
        errors++; $display("FAIL reset_outputs obs=%b exp=%b", obs_vec(), e);
      end
    end
    checks++;
    if (dbg.state !== ST_IDLE || dbg.hold_cnt !== 8'd0 || dbg.ptr !== 2'd3) begin
      errors++; $display("FAIL reset_internal state=%0d hold=%0d ptr=%0d exp 0/0/3", dbg.state, dbg.hold_cnt, dbg.ptr);
    end
    rst = 1'b0; bus.req = 4'b0000;
  endtask

  task automatic test_single();
    logic [W-1:0] e;
    logic [W-1:0] want [4];
    logic [3:0]   reqs [4];
    want = '{8'b0100_1001, 8'b0100_1011, 8'b0000_0010, 8'b0000_0000};
    reqs = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
    bus.d0 = 1'b0; bus.d1 = 1'b0; bus.d2 = 1'b1; bus.d3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req = reqs[i];
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== want[i] || obs_vec() !== e) begin
        errors++; $display("FAIL single_step%0d obs=%b exp=%b model=%b", i, obs_vec(), want[i], e);
      end
    end
  endtask

  task automatic test_rotation();
    logic [W-1:0] e;
    int seq [10];
    seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    rst = 1'b1; bus.req = 4'b0000; tick(); void'(exp_q.pop_front()); rst = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      bus.d0 = 1'($urandom_range(0, 1)); bus.d1 = 1'($urandom_range(0, 1));
      bus.d2 = 1'($urandom_range(0, 1)); bus.d3 = 1'($urandom_range(0, 1));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (bus.gnt !== 4'(1 << seq[i]) || {bus.s0, bus.s1} !== 2'(seq[i]) || obs_vec() !== e) begin
        errors++; $display("FAIL rotation_%0d gnt=%b sel=%b%b exp_idx=%0d model=%b", i, bus.gnt, bus.s0, bus.s1, seq[i], e);
      end
    end
    bus.req = 4'b0000; tick(); void'(exp_q.pop_front());
  endtask

  task automatic test_saturation();
    logic [W-1:0] e;
    rst = 1'b1; tick(); void'(exp_q.pop_front()); rst = 1'b0;
    bus.req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (bus.gnt !== 4'b0010 || dbg.hold_cnt !== 8'((i == 0) ? 1 : MAXH) || obs_vec() !== e) begin
        errors++; $display("FAIL saturation_%0d gnt=%b hold=%0d model=%b", i, bus.gnt, dbg.hold_cnt, e);
      end
    end
    bus.req = 4'b0000; tick(); void'(exp_q.pop_front());
  endtask

  task automatic test_wrap();
    logic [W-1:0] e;
    rst = 1'b1; tick(); void'(exp_q.pop_front()); rst = 1'b0;
    bus.req = 4'b1000; tick(); void'(exp_q.pop_front());
    bus.req = 4'b1001; tick(); void'(exp_q.pop_front());
    checks++;
    if (bus.gnt !== 4'b1000) begin
      errors++; $display("FAIL wrap_hold3 gnt=%b exp=1000", bus.gnt);
    end
    bus.req = 4'b0001; tick();
    e = exp_q.pop_front();
    checks++;
    if (bus.gnt !== 4'b0001 || {bus.s0, bus.s1} !== 2'b00 || bus.busy !== 1'b1 || obs_vec() !== e) begin
      errors++; $display("FAIL wrap_handoff gnt=%b sel=%b%b exp=0001/00 model=%b", bus.gnt, bus.s0, bus.s1, e);
    end
    bus.req = 4'b0000; tick(); void'(exp_q.pop_front());
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e;
    rst = 1'b1; tick(); void'(exp_q.pop_front()); rst = 1'b0;
    bus.req = 4'b0100; tick(); void'(exp_q.pop_front());
    checks++;
    if (bus.gnt !== 4'b0100) begin
      errors++; $display("FAIL midrst_pre gnt=%b exp=0100", bus.gnt);
    end
    rst = 1'b1; tick();
    e = exp_q.pop_front();
    checks++;
    if (bus.gnt !== 4'b0000 || obs_vec() !== e) begin
      errors++; $display("FAIL midrst_clear obs=%b exp=%b", obs_vec(), e);
    end
    rst = 1'b0; bus.req = 4'b0110; tick();
    e = exp_q.pop_front();
    checks++;
    if (bus.gnt !== 4'b0010 || obs_vec() !== e) begin
      errors++; $display("FAIL midrst_regrant gnt=%b exp=0010 model=%b", bus.gnt, e);
    end
    bus.req = 4'b0000; tick(); void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 59) == 0);
      bus.req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : bus.req ^ 4'(1 << $urandom_range(0, 3));
      bus.d0 = 1'($urandom); bus.d1 = 1'($urandom); bus.d2 = 1'($urandom); bus.d3 = 1'($urandom);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) begin
        errors++; $display("FAIL random_%0d req=%b obs=%b exp=%b", i, bus.req, obs_vec(), e);
      end
      checks++;
      if ($countones(bus.gnt) > 1 || (bus.gnt != 4'b0000 && bus.gnt !== 4'(1 << {bus.s0, bus.s1}))) begin
        errors++; $display("FAIL random_onehot_%0d gnt=%b sel=%b%b", i, bus.gnt, bus.s0, bus.s1);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 4'b0000;
    bus.d0 = 1'b0; bus.d1 = 1'b0; bus.d2 = 1'b0; bus.d3 = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_saturation();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
